// File: rtl/product_accumulator_pkg.sv
// Shared definitions for the product accumulator: FSM state encoding and default widths.
package product_accumulator_pkg;

    localparam int PROD_W_DEF    = 8;
    localparam int ACC_W_DEF     = 10;
    localparam int NUM_TERMS_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/product_accumulator_term_counter.sv
// Modulo-NUM_TERMS term counter; last flags the final term of a result.
module term_counter #(
    parameter int NUM_TERMS = 4,
    localparam int CNT_W = $clog2(NUM_TERMS)
) (
    input  logic clk,
    input  logic n_rst,
    input  logic inc,
    input  logic clr,
    output logic last
);

    logic [CNT_W-1:0] cnt;

    assign last = (cnt == CNT_W'(NUM_TERMS - 1));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= last ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/product_accumulator.sv
// Sums NUM_TERMS unsigned products per result with carry-based overflow reporting.
// Define ACC_SATURATE_EN to clamp on overflow instead of wrapping modulo 2^ACC_W.
//
// state | meaning
// IDLE  | waiting for the first product of a result
// ACCUM | collecting the remaining products
// HOLD  | result presented, waiting for out_ready
module product_accumulator
    import product_accumulator_pkg::*;
#(
    parameter int PROD_W    = PROD_W_DEF,
    parameter int ACC_W     = ACC_W_DEF,
    parameter int NUM_TERMS = NUM_TERMS_DEF
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] product,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  acc_out,
    output logic              ovf
);

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic             ovf_acc;
    logic             accept;
    logic             last;
    logic [ACC_W:0]   sum;
    logic             carry;
    logic [ACC_W-1:0] acc_next;
    logic             ovf_next;

    assign in_ready = (state != HOLD);
    assign accept   = in_valid & in_ready;

    // A new result starts from zero with the overflow history cleared.
    assign sum      = {1'b0, (state == IDLE) ? {ACC_W{1'b0}} : acc}
                    + {{(ACC_W + 1 - PROD_W){1'b0}}, product};
    assign carry    = sum[ACC_W];
    assign ovf_next = ((state == IDLE) ? 1'b0 : ovf_acc) | carry;

`ifdef ACC_SATURATE_EN
    assign acc_next = carry ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
    assign acc_next = sum[ACC_W-1:0];
`endif

    term_counter #(.NUM_TERMS(NUM_TERMS)) u_term_counter (
        .clk   (clk),
        .n_rst (n_rst),
        .inc   (accept & ~clr),
        .clr   (clr),
        .last  (last)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= IDLE;
            acc       <= '0;
            ovf_acc   <= 1'b0;
            acc_out   <= '0;
            out_valid <= 1'b0;
            ovf       <= 1'b0;
        end else if (clr) begin
            state     <= IDLE;
            acc       <= '0;
            ovf_acc   <= 1'b0;
            out_valid <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state   <= ACCUM;
                        acc     <= acc_next;
                        ovf_acc <= ovf_next;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        if (last) begin
                            state     <= HOLD;
                            acc_out   <= acc_next;
                            ovf       <= ovf_next;
                            out_valid <= 1'b1;
                        end else begin
                            acc     <= acc_next;
                            ovf_acc <= ovf_next;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        acc       <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// Scoreboard bench: two accumulators (ACC_W=10 and ACC_W=9) driven by identical product streams.
module tb_product_accumulator;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       clr;
    logic       in_valid;
    logic [7:0] product;
    logic       out_ready;

    logic       in_ready_a, out_valid_a, ovf_a;
    logic [9:0] acc_out_a;
    logic       in_ready_b, out_valid_b, ovf_b;
    logic [8:0] acc_out_b;

    always #5 clk = ~clk;

    product_accumulator dut_a (
        .clk(clk), .n_rst(n_rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready_a),
        .product(product), .out_valid(out_valid_a), .out_ready(out_ready),
        .acc_out(acc_out_a), .ovf(ovf_a)
    );

    product_accumulator #(.ACC_W(9)) dut_b (
        .clk(clk), .n_rst(n_rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready_b),
        .product(product), .out_valid(out_valid_b), .out_ready(out_ready),
        .acc_out(acc_out_b), .ovf(ovf_b)
    );

`ifdef ACC_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct {
        int acc;
        bit ovf;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   n_cmp    = 0;
    int   n_bad    = 0;
    int   pushed   = 0;
    int   pulses_a = 0;
    int   pulses_b = 0;
    int   rdy_mode = 0;

    // Monotonic unsigned sum: overflow means the total exceeds the width's maximum.
    function automatic exp_t model(input int total, input int w);
        exp_t e;
        int   mx;
        mx    = (1 << w) - 1;
        e.ovf = (total > mx);
        if (total > mx) e.acc = SAT ? mx : total % (1 << w);
        else            e.acc = total;
        return e;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: condition not met at %0t", name, $time);
    endtask

    initial begin
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            case (rdy_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: pops on the first cycle of each result, then checks it stays stable while held.
    initial begin
        bit   seen_a, seen_b;
        int   hold_acc_a, hold_acc_b;
        bit   hold_ovf_a, hold_ovf_b;
        exp_t e;
        seen_a = 0;
        seen_b = 0;
        hold_acc_a = 0; hold_acc_b = 0; hold_ovf_a = 0; hold_ovf_b = 0;
        forever begin
            @(negedge clk);
            if (out_valid_a) begin
                check("in_ready_low_in_hold_a", int'(in_ready_a), 0);
                if (!seen_a) begin
                    seen_a = 1;
                    pulses_a++;
                    if (q_a.size() == 0) fail_now("unexpected_result_a");
                    else begin
                        e = q_a.pop_front();
                        check("acc_out_a", int'(acc_out_a), e.acc);
                        check("ovf_a", int'(ovf_a), int'(e.ovf));
                        hold_acc_a = int'(acc_out_a);
                        hold_ovf_a = ovf_a;
                    end
                end else begin
                    check("hold_stable_acc_a", int'(acc_out_a), hold_acc_a);
                    check("hold_stable_ovf_a", int'(ovf_a), int'(hold_ovf_a));
                end
            end else seen_a = 0;

            if (out_valid_b) begin
                check("in_ready_low_in_hold_b", int'(in_ready_b), 0);
                if (!seen_b) begin
                    seen_b = 1;
                    pulses_b++;
                    if (q_b.size() == 0) fail_now("unexpected_result_b");
                    else begin
                        e = q_b.pop_front();
                        check("acc_out_b", int'(acc_out_b), e.acc);
                        check("ovf_b", int'(ovf_b), int'(e.ovf));
                        hold_acc_b = int'(acc_out_b);
                        hold_ovf_b = ovf_b;
                    end
                end else begin
                    check("hold_stable_acc_b", int'(acc_out_b), hold_acc_b);
                    check("hold_stable_ovf_b", int'(ovf_b), int'(hold_ovf_b));
                end
            end else seen_b = 0;
        end
    end

    // Caller is at a negedge; returns at the negedge after the product was accepted.
    task automatic send_one(input int v);
        int b;
        b = 0;
        while (!in_ready_a && b < 200) begin
            @(negedge clk);
            b++;
        end
        if (b >= 200) fail_now("in_ready_timeout");
        in_valid = 1'b1;
        product  = 8'(v);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic run_group(input int vals[4], input int gap, input bit push);
        int total;
        if (push) begin
            total = 0;
            foreach (vals[i]) total += vals[i];
            q_a.push_back(model(total, 10));
            q_b.push_back(model(total, 9));
            pushed++;
        end
        foreach (vals[i]) begin
            send_one(vals[i]);
            if (i != 3) repeat (gap) @(negedge clk);
        end
    endtask

    task automatic wait_drain();
        int b;
        b = 0;
        while ((q_a.size() != 0 || q_b.size() != 0 || out_valid_a) && b < 300) begin
            @(negedge clk);
            b++;
        end
        if (b >= 300) fail_now("drain_timeout");
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"}, int'(out_valid_a), 0);
        check({tag, "_in_ready"}, int'(in_ready_a), 1);
        check({tag, "_acc_out"}, int'(acc_out_a), 0);
        check({tag, "_ovf"}, int'(ovf_a), 0);
        check({tag, "_out_valid_b"}, int'(out_valid_b), 0);
        check({tag, "_acc_out_b"}, int'(acc_out_b), 0);
    endtask

    initial begin
        int vals[4];
        n_rst = 1'b0; clr = 1'b0; in_valid = 1'b0; product = '0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        n_rst = 1'b1;
        @(negedge clk);

        // Back-to-back terms, result held while out_ready is low.
        rdy_mode = 0;
        run_group('{3, 5, 7, 9}, 0, 1);
        check("latency_out_valid", int'(out_valid_a), 1);
        repeat (5) @(negedge clk);
        check("held_out_valid", int'(out_valid_a), 1);
        rdy_mode = 1;
        wait_drain();

        run_group('{225, 225, 225, 225}, 2, 1);
        wait_drain();

        run_group('{200, 200, 200, 200}, 0, 1);
        run_group('{1, 1, 1, 1}, 0, 1);
        wait_drain();

        // Abort a partial sum; the product offered with clr is dropped.
        send_one(50);
        send_one(60);
        clr = 1'b1; in_valid = 1'b1; product = 8'd99;
        @(negedge clk);
        clr = 1'b0; in_valid = 1'b0;
        check("clr_out_valid", int'(out_valid_a), 0);
        check("clr_in_ready", int'(in_ready_a), 1);
        run_group('{10, 20, 30, 40}, 0, 1);
        wait_drain();

        // Abort while holding a result.
        rdy_mode = 0;
        run_group('{1, 2, 3, 4}, 0, 1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("clr_hold_out_valid", int'(out_valid_a), 0);
        check("clr_hold_ovf", int'(ovf_a), 0);
        check("clr_hold_in_ready", int'(in_ready_a), 1);
        rdy_mode = 1;
        wait_drain();

        // Reset in ACCUM, then in HOLD.
        send_one(5);
        send_one(6);
        n_rst = 1'b0;
        #1;
        check_reset_outputs("rst_accum");
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        rdy_mode = 0;
        run_group('{7, 7, 7, 7}, 0, 1);
        @(negedge clk);
        n_rst = 1'b0;
        #1;
        check_reset_outputs("rst_hold");
        @(negedge clk);
        n_rst = 1'b1;
        rdy_mode = 1;
        @(negedge clk);
        run_group('{1, 2, 3, 4}, 0, 1);
        run_group('{5, 5, 5, 5}, 0, 1);
        wait_drain();

        rdy_mode = 2;
        for (int g = 0; g < 25; g++) begin
            foreach (vals[i]) vals[i] = int'($urandom_range(0, 255));
            run_group(vals, int'($urandom_range(0, 2)), 1);
        end
        wait_drain();

        check("queue_empty_a", q_a.size(), 0);
        check("queue_empty_b", q_b.size(), 0);
        check("pulse_count_a", pulses_a, pushed);
        check("pulse_count_b", pulses_b, pushed);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

endmodule
